// File: rtl/popcount_rr_scheduler.sv
// Purpose: round-robin sharing of one external pipelined popcount unit among N_REQ requesters.
// Latency: grant cycle to res_val_o is PC_LATENCY+2 cycles (transfer edge, PC_LATENCY counter stages, return register).
// Backpressure: none downstream; requesters are throttled only by the one-hot req_ready_o grant.
//
// Ports:
//   clk_i, arstn_i          clock, asynchronous active-low reset
//   en_i                    allows new grants; in-flight words always drain
//   req_data_i/req_val_i    packed requester words and valids
//   req_ready_o             one-hot grant (transfer when val & ready)
//   pc_srst_o/pc_data_o/pc_data_val_o   drive the shared counter
//   pc_data_i/pc_data_val_i             counter result path
//   res_data_o/res_id_o/res_val_o       returned (id, count) result
//   err_o                   sticky tag/counter desync flag
module popcount_rr_scheduler #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 24,
    parameter int PC_LATENCY = 3,
    parameter int CNT_W      = $clog2(WIDTH),
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   en_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]       req_val_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic                   pc_srst_o,
    output logic [WIDTH-1:0]       pc_data_o,
    output logic                   pc_data_val_o,
    input  logic [CNT_W-1:0]       pc_data_i,
    input  logic                   pc_data_val_i,
    output logic [CNT_W-1:0]       res_data_o,
    output logic [ID_W-1:0]        res_id_o,
    output logic                   res_val_o,
    output logic                   err_o
);

    // Tag pipe depth: one stage for the issue register plus one per counter stage,
    // so the tail lines up with pc_data_val_i.
    localparam int DEPTH  = PC_LATENCY + 1;
    localparam int SRST_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              srst_q, srst_d;
    logic [SRST_W-1:0] srst_cnt_q, srst_cnt_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  pc_data_q, pc_data_d;
    logic              pc_val_q;
    logic [DEPTH-1:0]  tag_val_q;
    logic [ID_W-1:0]   tag_id_q [DEPTH];
    logic [CNT_W-1:0]  res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q;
    logic              res_val_q;

    logic              eligible;
    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   idx;
    logic [N_REQ-1:0]  grant_oh;
    logic              transfer;
    logic              desync;

    // Round-robin search. Scanning from the farthest offset down to offset 0 and
    // overwriting on every hit leaves the nearest valid requester after ptr_q.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (req_val_i[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign eligible = en_i & ~srst_q & ~err_q;
    assign transfer = eligible & grant_found;

    always_comb begin
        grant_oh           = '0;
        grant_oh[grant_id] = 1'b1;
    end

    assign req_ready_o = transfer ? grant_oh : '0;

    always_comb begin
        ptr_d     = ptr_q;
        pc_data_d = '0;
        if (transfer) begin
            ptr_d     = ID_W'((int'(grant_id) + 1) % N_REQ);
            pc_data_d = req_data_i[int'(grant_id)*WIDTH +: WIDTH];
        end
    end

    // Counter sync reset: held through reset and for DEPTH cycles after release,
    // long enough to flush anything the counter held before reset.
    always_comb begin
        srst_cnt_d = srst_cnt_q;
        if (srst_cnt_q != '0) begin
            srst_cnt_d = srst_cnt_q - SRST_W'(1);
        end
        srst_d = (srst_cnt_q > SRST_W'(1));
    end

    // Counter output is meaningless while it is being reset, so only compare afterwards.
    assign desync = ~srst_q & (pc_data_val_i != tag_val_q[DEPTH-1]);
    assign err_d  = err_q | desync;

    // Count is only captured alongside a live tag; otherwise the last result is held.
    assign res_data_d = tag_val_q[DEPTH-1] ? pc_data_i : res_data_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ptr_q      <= '0;
            srst_q     <= 1'b1;
            srst_cnt_q <= SRST_W'(DEPTH);
            err_q      <= 1'b0;
            pc_data_q  <= '0;
            pc_val_q   <= 1'b0;
            tag_val_q  <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_id_q[s] <= '0;
            end
            res_data_q <= '0;
            res_id_q   <= '0;
            res_val_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            srst_q      <= srst_d;
            srst_cnt_q  <= srst_cnt_d;
            err_q       <= err_d;
            pc_data_q   <= pc_data_d;
            pc_val_q    <= transfer;
            tag_val_q   <= {tag_val_q[DEPTH-2:0], transfer};
            tag_id_q[0] <= grant_id;
            for (int s = 1; s < DEPTH; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
            res_data_q  <= res_data_d;
            res_id_q    <= tag_id_q[DEPTH-1];
            res_val_q   <= tag_val_q[DEPTH-1];
        end
    end

    assign pc_srst_o     = srst_q;
    assign pc_data_o     = pc_data_q;
    assign pc_data_val_o = pc_val_q;
    assign res_data_o    = res_data_q;
    assign res_id_o      = res_id_q;
    assign res_val_o     = res_val_q;
    assign err_o         = err_q;

endmodule
